// File: rtl/inert_spi_mstr.sv
// SPI mode-3 master: one 16-bit full-duplex frame per accepted wrt, done/rd_data handshake.
// Define INERT_SPI_FAST_SCLK_EN for SCLK = clk/16 (default SCLK = clk/32).
module inert_spi_mstr (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        done,
  output logic [15:0] rd_data
);

`ifdef INERT_SPI_FAST_SCLK_EN
  localparam int DIV_W = 4;
  localparam logic [DIV_W-1:0] DIV_LOAD = 4'b1011;
`else
  localparam int DIV_W = 5;
  localparam logic [DIV_W-1:0] DIV_LOAD = 5'b10111;
`endif
  localparam logic [DIV_W-1:0] DIV_MAX  = {DIV_W{1'b1}};
  localparam logic [DIV_W-1:0] DIV_HALF = {1'b0, {(DIV_W-1){1'b1}}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    FRONT = 3'b001,
    SHIFT = 3'b010,
    BACK  = 3'b100
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      shft_q, shft_d;
  logic             smpl_q, smpl_d;
  logic             ss_n_q, ss_n_d;
  logic             sclk_q, sclk_d;
  logic             done_q, done_d;
  logic             wrap_s, rise_s;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_cnt_q <= 4'd0;
      shft_q    <= 16'h0000;
      smpl_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shft_q    <= shft_d;
      smpl_q    <= smpl_d;
      ss_n_q    <= ss_n_d;
      sclk_q    <= sclk_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    shft_d    = shft_q;
    smpl_d    = smpl_q;
    ss_n_d    = ss_n_q;
    done_d    = done_q;
    wrap_s    = (div_q == DIV_MAX);
    rise_s    = (div_q == DIV_HALF);

    case (state_q)
      IDLE: begin
        if (wrt) begin
          shft_d    = cmd;
          div_d     = DIV_LOAD;
          bit_cnt_d = 4'd0;
          ss_n_d    = 1'b0;
          done_d    = 1'b0;
          state_d   = FRONT;
        end else begin
          state_d = IDLE;
        end
      end
      FRONT: begin
        // First falling edge only: MOSI already carries cmd[15]
        div_d = div_q + DIV_ONE;
        if (wrap_s) begin
          state_d = SHIFT;
        end else begin
          state_d = FRONT;
        end
      end
      SHIFT: begin
        div_d = div_q + DIV_ONE;
        if (rise_s) begin
          smpl_d = MISO;
          if (bit_cnt_q == 4'd15) begin
            state_d = BACK;
          end else begin
            state_d = SHIFT;
          end
        end else if (wrap_s) begin
          shft_d    = {shft_q[14:0], smpl_q};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else begin
          state_d = SHIFT;
        end
      end
      BACK: begin
        div_d = div_q + DIV_ONE;
        if (wrap_s) begin
          shft_d  = {shft_q[14:0], smpl_q};
          ss_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = BACK;
        end
      end
      default: begin
        state_d   = IDLE;
        div_d     = '0;
        bit_cnt_d = 4'd0;
        shft_d    = 16'h0000;
        smpl_d    = 1'b0;
        ss_n_d    = 1'b1;
        done_d    = 1'b0;
      end
    endcase

    // SCLK is registered from next state so it never glitches and parks high in IDLE
    if (state_d == IDLE) begin
      sclk_d = 1'b1;
    end else begin
      sclk_d = div_d[DIV_W-1];
    end
  end

  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_q;
  assign MOSI    = shft_q[15];
  assign done    = done_q;
  assign rd_data = shft_q;

endmodule

// File: tb/tb_inert_spi_mstr.sv
// Scoreboard bench for inert_spi_mstr: randomized and directed frames, mode-3 slave model,
// frame monitor checking MOSI word, MISO capture, SCLK phase timing and done latency.
`timescale 1ns/1ps
module tb_inert_spi_mstr;

`ifdef INERT_SPI_FAST_SCLK_EN
  localparam int HALF       = 8;
  localparam int FIRST_FALL = 5;
  localparam int DONE_OFF   = 261;
`else
  localparam int HALF       = 16;
  localparam int FIRST_FALL = 9;
  localparam int DONE_OFF   = 521;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wrt = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI, done;
  logic [15:0] rd_data;

  inert_spi_mstr dut (
    .clk(clk), .rst(rst), .wrt(wrt), .cmd(cmd), .MISO(MISO),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .done(done), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int nframes = 0;

  typedef struct {
    logic [15:0] mosi_word;
    logic [15:0] rd_word;
    int          done_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] slv_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Slave model and frame monitor, sampled on the falling clk edge
  logic        p_ss = 1'b1, p_sclk = 1'b1, p_mosi = 1'b0, p_done = 1'b0;
  logic        in_frame = 1'b0, ph_err = 1'b0;
  int          ss_cyc, last_cyc, rises, falls, frames = 0, slv_idx = 0;
  logic [15:0] mosi_bits, slv_word = 16'h0000;
  exp_t        e_mon;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      in_frame = 1'b0;
    end else begin
      if (p_ss && !SS_n) begin
        in_frame  = 1'b1;
        ss_cyc    = cyc;
        last_cyc  = cyc;
        rises     = 0;
        falls     = 0;
        ph_err    = 1'b0;
        mosi_bits = 16'h0000;
        frames++;
        slv_word  = (slv_q.size() > 0) ? slv_q.pop_front() : 16'h0000;
        slv_idx   = 0;
      end
      if (!SS_n && in_frame) begin
        if (p_sclk && !SCLK) begin
          falls++;
          if (falls == 1) begin
            if (cyc - ss_cyc != FIRST_FALL) ph_err = 1'b1;
          end else if (cyc - last_cyc != HALF) begin
            ph_err = 1'b1;
          end
          last_cyc = cyc;
          if (slv_idx < 16) begin
            MISO = slv_word[15 - slv_idx];
            slv_idx++;
          end
        end else if (!p_sclk && SCLK) begin
          rises++;
          if (cyc - last_cyc != HALF) ph_err = 1'b1;
          last_cyc  = cyc;
          mosi_bits = {mosi_bits[14:0], MOSI};
        end
        if ((MOSI !== p_mosi) && !(p_sclk && !SCLK) && !p_ss) ph_err = 1'b1;
      end
      if (!p_done && done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e_mon = exp_q.pop_front();
          chk("rd_data", rd_data, e_mon.rd_word);
          chk("mosi_word", mosi_bits, e_mon.mosi_word);
          chk("sclk_rises", rises, 16);
          chk("sclk_falls", falls, 16);
          chk("done_edge", cyc, e_mon.done_cyc);
          chk("ss_n_with_done", SS_n, 1);
          chk("phase_timing", {31'd0, ph_err} | ((cyc - last_cyc != HALF) ? 32'd2 : 32'd0), 0);
        end
        in_frame = 1'b0;
      end
    end
    p_ss   = SS_n;
    p_sclk = SCLK;
    p_mosi = MOSI;
    p_done = done;
  end

  // Issue a transaction at a falling clk edge; the next rising edge is E1
  task automatic issue(input logic [15:0] c, input logic [15:0] r);
    exp_t e;
    wrt = 1'b1;
    cmd = c;
    e.mosi_word = c;
    e.rd_word   = r;
    e.done_cyc  = cyc + 1 + DONE_OFF;
    exp_q.push_back(e);
    slv_q.push_back(r);
    nframes++;
    @(negedge clk);
    wrt = 1'b0;
    cmd = 16'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", done, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1;
    int bad;
    logic [15:0] r;

    repeat (5) @(negedge clk);
    chk("rst_ss_n", SS_n, 1);
    chk("rst_sclk", SCLK, 1);
    chk("rst_done", done, 0);
    chk("rst_rd_data", rd_data, 16'h0000);
    chk("rst_mosi", MOSI, 0);
    rst = 1'b0;

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      MISO = 1'($urandom);
      cmd  = 16'($urandom);
      if (SS_n !== 1'b1 || SCLK !== 1'b1 || done !== 1'b0 || rd_data !== 16'h0000 || MOSI !== 1'b0)
        bad++;
    end
    chk("idle_quiet_cycles_bad", bad, 0);

    issue(16'hA300, 16'h5AC3);
    wait_done();
    chk("single_rd_data", rd_data, 16'h5AC3);
    repeat (5) @(negedge clk);
    chk("done_sticky", done, 1);
    chk("rd_data_sticky", rd_data, 16'h5AC3);

    issue(16'h0D02, 16'h3C96);
    wait_done();
    chk("b2b_ss_high_at_done", SS_n, 1);
    issue(16'h1053, 16'hE001);
    chk("b2b_done_cleared", done, 0);
    chk("b2b_ss_low_again", SS_n, 0);
    wait_done();

    issue(16'h1460, 16'h7E81);
    e1 = cyc;
    repeat (98) @(negedge clk);
    wrt = 1'b1; cmd = 16'hFFFF;
    @(negedge clk);
    wrt = 1'b0;
    repeat (299) @(negedge clk);
    wrt = 1'b1; cmd = 16'hFFFF;
    @(negedge clk);
    wrt = 1'b0;
    chk("ignored_wrt_ss_low", SS_n, 0);
    chk("ignored_wrt_edge", cyc, e1 + 399);
    wait_done();

    issue(16'h2222, 16'hBEEF);
    repeat (298) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ss_n", SS_n, 1);
    chk("async_rst_sclk", SCLK, 1);
    chk("async_rst_done", done, 0);
    repeat (3) @(negedge clk);
    chk("async_rst_rd_data", rd_data, 16'h0000);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_done_low", done, 0);
    issue(16'h1150, 16'h00FF);
    wait_done();
    chk("post_rst_rd_data", rd_data, 16'h00FF);

    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(1, 0) == 1) repeat ($urandom_range(20, 1)) @(negedge clk);
      r = 16'($urandom);
      issue(16'($urandom), r);
      wait_done();
      chk("rand_rd_data", rd_data, r);
    end

    repeat (20) @(negedge clk);
    chk("frame_count", frames, nframes);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inert_spi_mstr.md
# inert_spi_mstr

SPI master that sits directly upstream of the inertial-sensor interface state machine. It shifts a 16-bit command out on MOSI and captures 16 bits from MISO in the same transaction, using SPI mode 3 (SCLK idles high, MOSI changes on falling edges, MISO is sampled on rising edges). The `wrt`/`done`/`rd_data` handshake supports back-to-back config writes and register reads: the consumer pulses `wrt` in the same cycle it observes `done`.

## Interface
Parameters: none. Timing is fixed, except the SCLK divide, which the macro in Configuration selects.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  **asynchronous, active-high reset**
- wrt  in  1  start-transaction strobe; honoured only in IDLE
- cmd  in  16  command/data word; sampled on the edge that accepts `wrt`
- MISO  in  1  serial data from the sensor
- SS_n  out  1  active-low slave select
- SCLK  out  1  serial clock (registered, glitch-free)
- MOSI  out  1  serial data to the sensor; equals `shft_reg[15]`
- done  out  1  transaction complete; stays high until the next accepted `wrt`
- rd_data  out  16  equals `shft_reg`; valid while `done` is high

## Operation
- Divider `sclk_div`: 5 bits by default. It increments every clk while not IDLE. `SCLK = sclk_div[MSB]` outside IDLE and 1 in IDLE.
- Reset values:
  - state = IDLE
  - SS_n = 1, SCLK = 1, done = 0
  - shft_reg = 0, so MOSI = 0 and rd_data = 0
  - bit_cnt = 0, sclk_div = 0, miso_smpl = 0
- States:
  - **IDLE**: on `wrt`:
    - shft_reg ← cmd, sclk_div ← 5'b10111, bit_cnt ← 0
    - SS_n ← 0, done ← 0
    - go to FRONT
  - **FRONT**: on the edge where sclk_div wraps 31→0, SCLK falls with no shift (MOSI already holds cmd[15]). Go to SHIFT.
  - **SHIFT**, on each clk edge:
    - sclk_div 15→16: SCLK rises and miso_smpl ← MISO.
    - sclk_div 31→0: shft_reg ← {shft_reg[14:0], miso_smpl} and bit_cnt++.
    - When the rise with bit_cnt == 15 occurs (the 16th rise), go to BACK.
  - **BACK**, on the edge where sclk_div reaches 31→0:
    - final shift; shft_reg now holds the full MISO word, MSB first
    - SCLK held at 1 (no 17th falling edge)
    - SS_n ← 1, done ← 1, go to IDLE
- `wrt` outside IDLE is ignored; `cmd` changes after acceptance have no effect.
- A `wrt` arriving in the same cycle `done` is high (IDLE) is accepted. `done` clears on that edge.
- Unused state encodings recover to IDLE with outputs at their reset values.

## Timing
- Edge numbering: the edge that samples `wrt` high is E1.
- Default divide-by-32 (SCLK = 1.5625 MHz):
  - E1: SS_n falls.
  - E10: first SCLK fall.
  - Rises at E26 + 32k, for k = 0..15; the 16th rise is at E506.
  - E522: done rises and SS_n rises simultaneously.
- Each SCLK phase is exactly 16 clk. SS_n low to first fall is 9 clk; last rise to SS_n high is 16 clk.
- MOSI changes only on the E10 + 32k edges (SCLK falls) and at E1. MISO is captured at SCLK rising edges.
- `rd_data` is combinationally `shft_reg`. The consumer latches it while `done` is high.
- Reset asserted mid-transaction: on assertion, SS_n = 1, SCLK = 1 and done = 0 immediately, with no partial completion. The first `wrt` after reset release starts a clean transaction.

## Configuration
- `INERT_SPI_FAST_SCLK_EN`
  - Defined: 4-bit divider, load value 4'b1011, SCLK = clk/16.
    - SS_n falls at E1.
    - First fall at E6.
    - Rises at E14 + 16k, for k = 0..15.
    - done and SS_n rise at E262.
  - Undefined: 5-bit divide-by-32 timing as above.
  - State machine and handshake are identical in both builds.

## Test plan
- Reset: hold `rst` = 1 mid-stream.
  - SS_n = 1, SCLK = 1, done = 0, rd_data = 16'h0000, MOSI = 0.
  - After release with no `wrt`, all outputs stay unchanged for 1000 clk.
- Single transaction: cmd = 16'hA300, MISO model returns 16'h5AC3.
  - MOSI bits at the 16 rises read 16'hA300.
  - done rises at E522 with rd_data = 16'h5AC3.
  - Exactly 16 SCLK falls and 16 rises while SS_n is low.
- Back-to-back: pulse `wrt` with cmd = 16'h1053 in the first cycle `done` is high after a 16'h0D02 transaction.
  - done clears on the next edge.
  - SS_n is high for exactly one cycle, then the second frame's MOSI reads 16'h1053.
- Ignored wrt: pulse `wrt` with cmd = 16'hFFFF at E100 and again at E400 during a 16'h1460 transaction.
  - MOSI frame still reads 16'h1460.
  - done still rises at E522, with no extra SS_n activity.
- Reset mid-operation: assert `rst` at E300.
  - SS_n and SCLK go to 1 asynchronously; done stays 0.
  - A following transaction with cmd = 16'h1150 and MISO = 16'h00FF completes normally with rd_data = 16'h00FF.
- Fast build (`INERT_SPI_FAST_SCLK_EN`): repeat the single-transaction scenario.
  - done rises at E262.
  - SCLK high and low phases are each 8 clk.
